// File: rtl/decoder_select_seq.sv
// Select sequencer for the 2-to-4 decoder: free-running scan or 4-phase single steps.
// Optional registered one-hot output enabled by defining SEL_ONEHOT_EN.
module decoder_select_seq #(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    input  logic             step_req,
    output logic             step_ack,
    output logic             S1,
    output logic             S0,
    output logic             wrap,
`ifdef SEL_ONEHOT_EN
    output logic [3:0]       onehot,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // A divider default that does not fit the divider width is a build error.
    if (DIV_RESET < 1 || DIV_RESET > (2**DIV_W) - 1) begin : g_bad_div_reset
        $error("DIV_RESET out of range for DIV_W");
    end

    state_t           state;
    logic [1:0]       sel;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] eff;
    logic [1:0]       sel_next;
    logic             wrap_next;
    logic             run_due;
    logic             adv;

    // Using >= rather than == means a divider shrunk below the count fires at once.
    always_comb begin
        eff       = (div == '0) ? ONE : div;
        sel_next  = dir ? (sel - 2'd1) : (sel + 2'd1);
        wrap_next = dir ? (sel == 2'd0) : (sel == 2'd3);
        run_due   = (presc >= (eff - ONE));
        adv       = ((state == IDLE) && !run && step_req) ||
                    ((state == RUN) && run && run_due);
    end

    assign S1 = sel[1];
    assign S0 = sel[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 2'd0;
            presc    <= '0;
            step_ack <= 1'b0;
            wrap     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wrap <= adv && wrap_next;
            if (adv) begin
                sel <= sel_next;
            end
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= RUN;
                        presc <= '0;
                        busy  <= 1'b1;
                    end else if (step_req) begin
                        state    <= STEP;
                        step_ack <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state <= IDLE;
                        presc <= '0;
                        busy  <= 1'b0;
                    end else if (run_due) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + ONE;
                    end
                end
                STEP: begin
                    if (!step_req) begin
                        state    <= IDLE;
                        step_ack <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    step_ack <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEL_ONEHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot <= 4'b0001;
        end else if (adv) begin
            onehot <= 4'b0001 << sel_next;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_select_seq.sv
// Directed bench for decoder_select_seq: run up/down scans, divider shrink, handshake, reset.
module tb_decoder_select_seq;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       dir;
    logic [7:0] div;
    logic       step_req;
    logic       step_ack;
    logic       S1;
    logic       S0;
    logic       wrap;
    logic       busy;
`ifdef SEL_ONEHOT_EN
    logic [3:0] onehot;
`endif

    int checks;
    int errors;

    decoder_select_seq #(.DIV_W(8), .DIV_RESET(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .dir      (dir),
        .div      (div),
        .step_req (step_req),
        .step_ack (step_ack),
        .S1       (S1),
        .S0       (S0),
        .wrap     (wrap),
`ifdef SEL_ONEHOT_EN
        .onehot   (onehot),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks select, wrap, ack and busy together at the current sample point.
    task automatic check_all(input string tag, input logic [1:0] e_sel, input logic e_wrap,
                             input logic e_ack, input logic e_busy);
        check_output({tag, ".sel"},  {2'b00, S1, S0}, {2'b00, e_sel});
        check_output({tag, ".wrap"}, {3'b000, wrap},  {3'b000, e_wrap});
        check_output({tag, ".ack"},  {3'b000, step_ack}, {3'b000, e_ack});
        check_output({tag, ".busy"}, {3'b000, busy},  {3'b000, e_busy});
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        run      = 1'b0;
        dir      = 1'b0;
        div      = 8'd0;
        step_req = 1'b0;

        // Asynchronous reset before the first clock edge.
        #3 rst_n = 1'b0;
        #1 check_all("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(2);
        rst_n = 1'b1;
        apply_stimulus(1);
        check_all("idle", 2'd0, 1'b0, 1'b0, 1'b0);

        // Run up with div=3: first advance three edges after entering RUN.
        run = 1'b1; dir = 1'b0; div = 8'd3;
        apply_stimulus(1);
        check_all("up.enter", 2'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(2);
        check_all("up.wait", 2'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("up.s1", 2'd1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(3);
        check_all("up.s2", 2'd2, 1'b0, 1'b0, 1'b1);
        apply_stimulus(3);
        check_all("up.s3", 2'd3, 1'b0, 1'b0, 1'b1);
        apply_stimulus(3);
        check_all("up.wrap", 2'd0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("up.post", 2'd0, 1'b0, 1'b0, 1'b1);

        // step_req during RUN is ignored and scan timing is unchanged.
        step_req = 1'b1;
        apply_stimulus(1);
        check_all("run.req", 2'd0, 1'b0, 1'b0, 1'b1);
        step_req = 1'b0;
        apply_stimulus(1);
        check_all("run.adv", 2'd1, 1'b0, 1'b0, 1'b1);

        // Leaving RUN holds sel.
        run = 1'b0;
        apply_stimulus(1);
        check_all("stop", 2'd1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1);
        check_all("stop.hold", 2'd1, 1'b0, 1'b0, 1'b0);

        // Divider shrink: div=10, prescaler reaches 7, then div=2.
        run = 1'b1; div = 8'd10;
        apply_stimulus(1);
        check_all("shr.enter", 2'd1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(7);
        check_all("shr.p7", 2'd1, 1'b0, 1'b0, 1'b1);
        div = 8'd2;
        apply_stimulus(1);
        check_all("shr.force", 2'd2, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("shr.hold", 2'd2, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("shr.next", 2'd3, 1'b0, 1'b0, 1'b1);
        apply_stimulus(2);
        check_all("shr.wrap", 2'd0, 1'b1, 1'b0, 1'b1);
        run = 1'b0;
        apply_stimulus(1);
        check_all("shr.stop", 2'd0, 1'b0, 1'b0, 1'b0);

        // Run down with div=0 (treated as 1): advance every cycle.
        run = 1'b1; dir = 1'b1; div = 8'd0;
        apply_stimulus(1);
        check_all("dn.enter", 2'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("dn.s3", 2'd3, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("dn.s2", 2'd2, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("dn.s1", 2'd1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("dn.s0", 2'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("dn.wrap2", 2'd3, 1'b1, 1'b0, 1'b1);

        // Reset mid-scan, mid-cycle, observed before the next edge.
        #2 rst_n = 1'b0;
        #1 check_all("reset.mid", 2'd0, 1'b0, 1'b0, 1'b0);
        run = 1'b0; dir = 1'b0;
        apply_stimulus(1);
        rst_n = 1'b1;
        apply_stimulus(1);
        check_all("reset.rel", 2'd0, 1'b0, 1'b0, 1'b0);

        // Single step held for five edges, with run raised mid-handshake.
        step_req = 1'b1;
        apply_stimulus(1);
        check_all("step.ack", 2'd1, 1'b0, 1'b1, 1'b1);
        run = 1'b1;
        apply_stimulus(3);
        check_all("step.held", 2'd1, 1'b0, 1'b1, 1'b1);
        apply_stimulus(1);
        check_all("step.once", 2'd1, 1'b0, 1'b1, 1'b1);
        step_req = 1'b0;
        apply_stimulus(1);
        check_all("step.done", 2'd1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1);
        check_all("step.torun", 2'd1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1);
        check_all("step.runadv", 2'd2, 1'b0, 1'b0, 1'b1);

        run = 1'b0;
        apply_stimulus(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
